pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 160, meaning the datapath payload width in bits (operands, immediate, PC, PC+4).
REQ-002 The block SHALL have parameter CTRL_W, default 24, meaning the control payload width in bits (write enables, source selects, ALU control, register indices).
REQ-003 The block SHALL have parameter CLR_DATA, default 1, meaning flush also zeroes stored data (1) or zeroes control only (0).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous kill of all held entries (branch, jump or cache-miss flush).
REQ-007 The block SHALL have port in_valid, input, 1 bit: the upstream stage offers an entry.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts an entry this cycle.
REQ-009 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control payload.
REQ-010 The block SHALL have port in_data, input, DATA_W bits: upstream data payload.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the head entry.
REQ-013 The block SHALL have port out_ctrl, output, CTRL_W bits: head control payload.
REQ-014 The block SHALL have port out_data, output, DATA_W bits: head data payload.
REQ-015 The block SHALL have port occupancy, output, 2 bits: number of held entries (0 to 2).

Function
REQ-016 A transfer SHALL occur on a rising edge when the valid and ready of the same side are both 1; payload SHALL appear on out_* one cycle after acceptance (latency 1).
REQ-017 The block SHALL contain a head register and a skid register, with states EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-018 in_ready SHALL equal (state != FULL) and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-019 EMPTY SHALL go to ONE on accept.
REQ-020 ONE SHALL behave as follows: accept without pop goes to FULL (entry into skid); pop without accept goes to EMPTY; accept with pop stays ONE (entry into head).
REQ-021 FULL SHALL go to ONE on pop, with the skid entry moving to the head in the same edge; no accept is possible in FULL.
REQ-022 Entry order SHALL be preserved; an entry SHALL never be duplicated or dropped without a flush.
REQ-023 out_ctrl SHALL be all zeros whenever out_valid=0, so that an invalid head is a bubble and no write enable leaks downstream.
REQ-024 When flush=1, on the next edge the state SHALL become EMPTY and all ctrl registers SHALL be zeroed; data registers SHALL be zeroed only if CLR_DATA=1.
REQ-025 Flush SHALL take priority over a simultaneous accept or pop: the offered entry is discarded, and out_valid is 0 the next cycle.
REQ-026 in_ready SHALL remain driven by state during flush; an upstream handshake in the flush cycle SHALL count as consumed and discarded.

Reset
REQ-027 While rst=0, asynchronously: state SHALL be EMPTY, occupancy 0, out_valid 0, in_ready 1, and out_ctrl and out_data all zeros.
REQ-028 Reset asserted mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-029 Reset deassertion SHALL be synchronised externally; the first accept SHALL be possible on the first edge after release.

Configuration
REQ-030 With macro PIPE_STAGE_SKID_EN defined, the two-entry skid behaviour of REQ-017 to REQ-021 SHALL apply.
REQ-031 Without PIPE_STAGE_SKID_EN, the block SHALL be a single register with in_ready = !out_valid | out_ready (combinational), occupancy at most 1, and the skid register and FULL state absent; all other requirements SHALL still hold.

Structure
REQ-032 A shared package pipe_pkg SHALL hold the state enum (EMPTY, ONE, FULL), the default width constants, and the typedef of the control bundle used by the ID/EX instances.
REQ-033 One sub-module, pipe_slot, SHALL be used: a single valid+payload register with load, clear-ctrl and clear-data inputs, instantiated once for the head and once for the skid.

Verification
REQ-034 Reset then in_valid=1 with in_ctrl=0x000ABC and out_ready=1: out_valid=1 and out_ctrl=0x000ABC on the next cycle, with occupancy 1.
REQ-035 out_ready=0 with entries A and B pushed on consecutive edges: occupancy goes 1, 2; in_ready=0; a third push C is not accepted; out_ready=1 yields A, then B, then C in order.
REQ-036 flush=1 with occupancy=2 and in_valid=1: next cycle out_valid=0, out_ctrl=0, occupancy 0; with CLR_DATA=1 out_data=0, and with CLR_DATA=0 out_data holds its old value.
REQ-037 rst pulsed low between edges while FULL: out_valid and occupancy drop to 0 immediately, without a clock edge.
REQ-038 Random in_valid/out_ready with 10,000 entries carrying sequence numbers: the output sequence is strictly incrementing and out_ctrl=0 whenever out_valid=0.
REQ-039 Build without PIPE_STAGE_SKID_EN: with out_ready=0 and out_valid=1, in_ready=0 in the same cycle, and occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy state, default
// payload widths, and the ID/EX control bundle carried through the ctrl lane.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

   typedef struct packed {
      logic       reg_we;
      logic       mem_we;
      logic       mem_re;
      logic       wb_sel;
      logic       alu_src_b;
      logic [3:0] alu_op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } idex_ctrl_t;

   localparam int PIPE_DATA_W = 160;
   localparam int PIPE_CTRL_W = $bits(idex_ctrl_t);

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register. Clear beats load; clearing ctrl also drops valid
// so an empty slot never presents a live write enable.
module pipe_slot #(
   parameter int CTRL_W = 24,
   parameter int DATA_W = 160
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              clr_ctrl_i,
   input  logic              clr_data_i,
   input  logic              valid_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (clr_ctrl_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (load_i) begin
         valid_q <= valid_i;
         ctrl_q  <= ctrl_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else if (clr_data_i) begin
         data_q <= '0;
      end else if (load_i && !clr_ctrl_i) begin
         data_q <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN for the two-entry head+skid version; default is a single register.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | head holds an entry
// FULL  | head and skid both hold entries, in_ready=0 (skid build only)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W   = PIPE_DATA_W,
   parameter int CTRL_W   = PIPE_CTRL_W,
   parameter int CLR_DATA = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   localparam bit CLR_DATA_EN = (CLR_DATA != 0);

   pipe_state_e state_q, state_d;

   logic              accept;
   logic              pop;
   logic              head_load;
   logic              head_clr;
   logic              head_valid;
   logic              head_valid_d;
   logic [CTRL_W-1:0] head_ctrl_d;
   logic [DATA_W-1:0] head_data_d;
   logic              data_clr;

   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign data_clr  = flush && CLR_DATA_EN;
   assign out_valid = head_valid;
   assign occupancy = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= EMPTY;
      else      state_q <= state_d;
   end

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
      .clk        (clk),
      .rst        (rst),
      .load_i     (head_load),
      .clr_ctrl_i (head_clr),
      .clr_data_i (data_clr),
      .valid_i    (head_valid_d),
      .ctrl_i     (head_ctrl_d),
      .data_i     (head_data_d),
      .valid_o    (head_valid),
      .ctrl_o     (out_ctrl),
      .data_o     (out_data)
   );

`ifdef PIPE_STAGE_SKID_EN

   logic              skid_load;
   logic              skid_clr;
   logic              head_from_skid;
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   // Registered-only ready: the skid slot absorbs the entry accepted while stalled.
   assign in_ready     = (state_q != FULL);
   assign head_valid_d = head_from_skid ? skid_valid : 1'b1;
   assign head_ctrl_d  = head_from_skid ? skid_ctrl  : in_ctrl;
   assign head_data_d  = head_from_skid ? skid_data  : in_data;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load_i     (skid_load),
      .clr_ctrl_i (skid_clr),
      .clr_data_i (data_clr),
      .valid_i    (1'b1),
      .ctrl_i     (in_ctrl),
      .data_i     (in_data),
      .valid_o    (skid_valid),
      .ctrl_o     (skid_ctrl),
      .data_o     (skid_data)
   );

   always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
      head_clr       = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         state_d  = EMPTY;
         head_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  head_load = 1'b1;
                  state_d   = ONE;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  skid_load = 1'b1;
                  state_d   = FULL;
               end else if (!accept && pop) begin
                  head_clr = 1'b1;
                  state_d  = EMPTY;
               end else if (accept && pop) begin
                  head_load = 1'b1;
               end
            end
            FULL: begin
               if (pop) begin
                  head_load      = 1'b1;
                  head_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_d        = ONE;
               end
            end
            default: begin
               state_d  = EMPTY;
               head_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

`else

   // Single register: ready passes through from downstream when the head is held.
   assign in_ready     = !head_valid || out_ready;
   assign head_valid_d = 1'b1;
   assign head_ctrl_d  = in_ctrl;
   assign head_data_d  = in_data;

   always_comb begin
      state_d   = state_q;
      head_load = 1'b0;
      head_clr  = 1'b0;
      if (flush) begin
         state_d  = EMPTY;
         head_clr = 1'b1;
      end else if (accept) begin
         head_load = 1'b1;
         state_d   = ONE;
      end else if (pop) begin
         head_clr = 1'b1;
         state_d  = EMPTY;
      end
   end

`endif

endmodule
